// File: rtl/vld_controller.sv
// ----------------------------------------------------------------------------
// vld_controller
//
// Purpose:
//   Sits between an upstream word source, a variable-length bit-buffer
//   decoder and a downstream symbol consumer. Upstream words are passed
//   straight into the decoder. The controller peeks at the decoder's MSB-first
//   window (dec_q), works out the length of the next code from its two-bit
//   prefix, and pulls the code out once the decoder holds enough bits. The
//   code is then offered downstream and the decoder is told how many bits to
//   drop.
//
// Code length from the prefix dec_q[WIDTH_OUT-1:WIDTH_OUT-2]:
//   00 -> 2, 01 -> 4, 10 -> 6, 11 -> 8 bits
//
// Ports:
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   asynchronous active-low reset (also resets the decoder)
//   in_valid   in   upstream word available
//   in_ready   out  decoder can take a word this cycle
//   in_data    in   upstream word (WIDTH_IN)
//   dec_push   out  push strobe to the decoder
//   dec_d      out  word pushed to the decoder (in_data passthrough)
//   dec_full   in   decoder buffer full
//   dec_size   in   number of valid bits held by the decoder
//   dec_pop    out  number of bits the decoder should consume
//   dec_q      in   next stream bits from the decoder, MSB first
//   sym_valid  out  decoded symbol available
//   sym_ready  in   downstream accepts the symbol
//   sym        out  decoded code bits, right-justified, zero-extended
//   sym_len    out  length of sym in bits
//   sym_count  out  (VLD_CTRL_STATS_EN only) accepted-symbol counter, 16 bits
//
// Build option:
//   VLD_CTRL_STATS_EN  adds the sym_count output and its counter.
// ----------------------------------------------------------------------------
module vld_controller #(
   parameter int  WIDTH_IN     = 8,
   parameter int  WIDTH_OUT    = 8,
   parameter int  BUFFER_WIDTH = 16,
   localparam int SIZE_W       = $clog2(BUFFER_WIDTH - 1) + 1,
   localparam int LEN_W        = $clog2(WIDTH_OUT - 1) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_IN-1:0]  in_data,
   output logic                 dec_push,
   output logic [WIDTH_IN-1:0]  dec_d,
   input  logic                 dec_full,
   input  logic [SIZE_W-1:0]    dec_size,
   output logic [LEN_W-1:0]     dec_pop,
   input  logic [WIDTH_OUT-1:0] dec_q,
   output logic                 sym_valid,
   input  logic                 sym_ready,
   output logic [WIDTH_OUT-1:0] sym,
   output logic [LEN_W-1:0]     sym_len
`ifdef VLD_CTRL_STATS_EN
   ,
   output logic [15:0]          sym_count
`endif
);

   typedef enum logic [1:0] {
      FILL,
      EMIT,
      HOLD,
      SETTLE
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 load_sym;
   logic [WIDTH_OUT-1:0] sym_reg;
   logic [LEN_W-1:0]     sym_len_reg;
   logic [1:0]           prefix;
   logic [LEN_W-1:0]     code_len;
   logic [LEN_W-1:0]     shift_amt;
   logic [WIDTH_OUT-1:0] code_bits;
   logic                 code_avail;

   // The upstream side never waits on the FSM: words flow into the decoder
   // whenever it has room, even while a symbol is being popped.
   assign in_ready = !dec_full;
   assign dec_push = in_valid && !dec_full;
   assign dec_d    = in_data;

   // Length of the code at the head of the window is 2 * (prefix + 1).
   // The code itself is the top code_len bits of the window, shifted down so
   // it comes out right-justified. A code is only taken once the decoder
   // actually holds all of its bits (and at least the two prefix bits, so the
   // prefix itself is trustworthy).
   assign prefix     = dec_q[WIDTH_OUT-1 -: 2];
   assign code_len   = LEN_W'({prefix, 1'b0}) + LEN_W'(2);
   assign shift_amt  = LEN_W'(WIDTH_OUT) - code_len;
   assign code_bits  = dec_q >> shift_amt;
   assign code_avail = (int'(dec_size) >= 2) && (int'(dec_size) >= int'(code_len));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // Symbol holding registers. They are only written in FILL, so they stay
   // frozen for the whole time the symbol is offered downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_reg     <= '0;
         sym_len_reg <= '0;
      end else if (load_sym) begin
         sym_reg     <= code_bits;
         sym_len_reg <= code_len;
      end
   end

   // Next-state and output decode. The pop is issued in EMIT only, so each
   // symbol is removed from the decoder exactly once no matter how long the
   // consumer stalls. After an accepted EMIT the SETTLE cycle gives the
   // decoder time to present its updated window and size before FILL looks
   // at them again; a HOLD that ends already spans that update.
   always_comb begin
      state_next = state;
      load_sym   = 1'b0;
      sym_valid  = 1'b0;
      dec_pop    = '0;
      case (state)
         FILL: begin
            if (code_avail) begin
               load_sym   = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            sym_valid  = 1'b1;
            dec_pop    = sym_len_reg;
            state_next = sym_ready ? SETTLE : HOLD;
         end
         HOLD: begin
            sym_valid = 1'b1;
            if (sym_ready) begin
               state_next = FILL;
            end
         end
         SETTLE: begin
            state_next = FILL;
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   assign sym     = sym_reg;
   assign sym_len = sym_len_reg;

`ifdef VLD_CTRL_STATS_EN
   // Count every symbol handed downstream; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_count <= '0;
      end else if (sym_valid && sym_ready) begin
         sym_count <= sym_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vld_controller.sv
// ----------------------------------------------------------------------------
// tb_vld_controller
//
// Bench for vld_controller with default parameters. A small bit-queue model
// stands in for the decoder (push appends MSB first, pop drops bits from the
// front, dec_q shows the first 8 bits zero-padded). Directed scenarios cover
// reset, the 0xAB / 0x00 stream, consumer back-pressure, reset while holding
// a symbol and decoder-full back-pressure; a randomized run compares every
// handed-over symbol against codes parsed directly from the accepted bytes.
// ----------------------------------------------------------------------------
module tb_vld_controller;

   localparam int WIDTH_IN     = 8;
   localparam int WIDTH_OUT    = 8;
   localparam int BUFFER_WIDTH = 16;
   localparam int SIZE_W       = $clog2(BUFFER_WIDTH - 1) + 1;
   localparam int LEN_W        = $clog2(WIDTH_OUT - 1) + 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [WIDTH_IN-1:0]  in_data = '0;
   logic                 dec_push;
   logic [WIDTH_IN-1:0]  dec_d;
   logic                 dec_full;
   logic [SIZE_W-1:0]    dec_size = '0;
   logic [LEN_W-1:0]     dec_pop;
   logic [WIDTH_OUT-1:0] dec_q = '0;
   logic                 sym_valid;
   logic                 sym_ready = 1'b0;
   logic [WIDTH_OUT-1:0] sym;
   logic [LEN_W-1:0]     sym_len;
`ifdef VLD_CTRL_STATS_EN
   logic [15:0]          sym_count;
`endif

   logic                 force_full = 1'b0;
   logic                 model_full = 1'b0;
   bit                   model_bits[$];
   logic [WIDTH_OUT-1:0] model_q;

   int checks = 0;
   int passes = 0;

   assign dec_full = force_full || model_full;

   vld_controller #(
      .WIDTH_IN     (WIDTH_IN),
      .WIDTH_OUT    (WIDTH_OUT),
      .BUFFER_WIDTH (BUFFER_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .dec_push  (dec_push),
      .dec_d     (dec_d),
      .dec_full  (dec_full),
      .dec_size  (dec_size),
      .dec_pop   (dec_pop),
      .dec_q     (dec_q),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym       (sym),
      .sym_len   (sym_len)
`ifdef VLD_CTRL_STATS_EN
      ,
      .sym_count (sym_count)
`endif
   );

   always #5 clk = ~clk;

   // Decoder stand-in: a bit queue, cleared by the shared reset, updated on
   // the rising edge from the pop and push strobes, and reporting full once
   // another word would not fit.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_bits.delete();
         dec_q      <= '0;
         dec_size   <= '0;
         model_full <= 1'b0;
      end else begin
         for (int i = 0; i < int'(dec_pop); i++) begin
            if (model_bits.size() > 0) void'(model_bits.pop_front());
         end
         if (dec_push) begin
            for (int i = WIDTH_IN - 1; i >= 0; i--) model_bits.push_back(dec_d[i]);
         end
         model_q = '0;
         for (int i = 0; i < WIDTH_OUT; i++) begin
            if (i < model_bits.size()) model_q[WIDTH_OUT-1-i] = model_bits[i];
         end
         dec_q      <= model_q;
         dec_size   <= SIZE_W'(model_bits.size());
         model_full <= (model_bits.size() > BUFFER_WIDTH - WIDTH_IN);
      end
   end

   // Pulse reset low in the low phase of the clock and release it again.
   task automatic do_reset();
      @(negedge clk);
      in_valid   = 1'b0;
      force_full = 1'b0;
      rst        = 1'b0;
      #1;
      rst        = 1'b1;
   endtask

   // Values straight out of an asynchronous reset, before any clock edge acts.
   task automatic test_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (sym_valid !== 1'b0) $display("[TB] FAIL reset_sym_valid: got %0b, expected 0", sym_valid);
      else passes++;
      checks++;
      if (dec_pop !== '0) $display("[TB] FAIL reset_dec_pop: got %0d, expected 0", dec_pop);
      else passes++;
      checks++;
      if (sym !== '0) $display("[TB] FAIL reset_sym: got %0h, expected 0", sym);
      else passes++;
      checks++;
      if (sym_len !== '0) $display("[TB] FAIL reset_sym_len: got %0d, expected 0", sym_len);
      else passes++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // 0xAB gives a 6-bit code 101010 = 0x2A, leaving "11" (needs 8 bits) to
   // stall; a following 0x00 completes the 8-bit code 11000000 = 0xC0.
   task automatic test_stream();
      do_reset();
      sym_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hAB;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (sym_valid !== 1'b0) $display("[TB] FAIL ab_early_valid: got %0b, expected 0", sym_valid);
      else passes++;
      @(negedge clk);
      #1;
      checks++;
      if (sym_valid !== 1'b1 || dec_pop !== 4'd6 || sym !== 8'h2A || sym_len !== 4'd6)
         $display("[TB] FAIL ab_emit: got valid=%0b pop=%0d sym=%0h len=%0d, expected valid=1 pop=6 sym=2a len=6",
                  sym_valid, dec_pop, sym, sym_len);
      else passes++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (sym_valid !== 1'b0 || dec_pop !== '0)
            $display("[TB] FAIL ab_stall: got valid=%0b pop=%0d, expected valid=0 pop=0", sym_valid, dec_pop);
         else passes++;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (sym_valid !== 1'b0) $display("[TB] FAIL c0_early_valid: got %0b, expected 0", sym_valid);
      else passes++;
      @(negedge clk);
      #1;
      checks++;
      if (sym_valid !== 1'b1 || dec_pop !== 4'd8 || sym !== 8'hC0 || sym_len !== 4'd8)
         $display("[TB] FAIL c0_emit: got valid=%0b pop=%0d sym=%0h len=%0d, expected valid=1 pop=8 sym=c0 len=8",
                  sym_valid, dec_pop, sym, sym_len);
      else passes++;
   endtask

   // 0x5C = 0101 1100: a 4-bit code 0x5 offered while the consumer stalls.
   task automatic test_hold();
      do_reset();
      sym_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5C;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (sym_valid !== 1'b1 || dec_pop !== 4'd4 || sym !== 8'h05 || sym_len !== 4'd4)
         $display("[TB] FAIL hold_emit: got valid=%0b pop=%0d sym=%0h len=%0d, expected valid=1 pop=4 sym=5 len=4",
                  sym_valid, dec_pop, sym, sym_len);
      else passes++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (sym_valid !== 1'b1 || dec_pop !== '0 || sym !== 8'h05 || sym_len !== 4'd4)
            $display("[TB] FAIL hold_stable: got valid=%0b pop=%0d sym=%0h len=%0d, expected valid=1 pop=0 sym=5 len=4",
                     sym_valid, dec_pop, sym, sym_len);
         else passes++;
      end
      sym_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (sym_valid !== 1'b0 || dec_pop !== '0)
         $display("[TB] FAIL hold_release: got valid=%0b pop=%0d, expected valid=0 pop=0", sym_valid, dec_pop);
      else passes++;
   endtask

   // Reset while a symbol is held: everything clears at once, and since the
   // decoder is emptied by the same reset nothing is emitted afterwards.
   task automatic test_reset_mid_hold();
      do_reset();
      sym_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5C;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sym_valid !== 1'b1) $display("[TB] FAIL mid_hold_pre: got valid=%0b, expected 1", sym_valid);
      else passes++;
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (sym_valid !== 1'b0 || dec_pop !== '0 || sym !== '0 || sym_len !== '0)
         $display("[TB] FAIL mid_hold_reset: got valid=%0b pop=%0d sym=%0h len=%0d, expected all 0",
                  sym_valid, dec_pop, sym, sym_len);
      else passes++;
      @(negedge clk);
      rst       = 1'b1;
      sym_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (sym_valid !== 1'b0 || dec_pop !== '0)
            $display("[TB] FAIL mid_hold_after: got valid=%0b pop=%0d, expected valid=0 pop=0", sym_valid, dec_pop);
         else passes++;
      end
   endtask

   // Decoder full blocks the push; the push reappears in the same cycle the
   // full flag drops.
   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      force_full = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h3C;
      #1;
      checks++;
      if (in_ready !== 1'b0 || dec_push !== 1'b0)
         $display("[TB] FAIL full_block: got ready=%0b push=%0b, expected ready=0 push=0", in_ready, dec_push);
      else passes++;
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || dec_push !== 1'b0)
         $display("[TB] FAIL full_block2: got ready=%0b push=%0b, expected ready=0 push=0", in_ready, dec_push);
      else passes++;
      force_full = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || dec_push !== 1'b1 || dec_d !== 8'h3C)
         $display("[TB] FAIL full_release: got ready=%0b push=%0b d=%0h, expected ready=1 push=1 d=3c",
                  in_ready, dec_push, dec_d);
      else passes++;
      in_valid = 1'b0;
   endtask

   // Random traffic. Expected symbols come from parsing the accepted byte
   // stream directly: length 2*(prefix+1), value = those bits MSB first.
   task automatic test_random();
      bit                   ref_bits[$];
      bit                   prev_hold;
      logic [WIDTH_OUT-1:0] prev_sym;
      logic [LEN_W-1:0]     prev_len;
      bit                   exp_push;
      int                   exp_len;
      int                   exp_sym;
      int                   handshakes;
      do_reset();
      prev_hold  = 1'b0;
      prev_sym   = '0;
      prev_len   = '0;
      handshakes = 0;
      for (int c = 0; c < 3040; c++) begin
         @(negedge clk);
         if (c < 3000) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = WIDTH_IN'($urandom);
            sym_ready  = ($urandom_range(0, 3) != 0);
            force_full = ($urandom_range(0, 7) == 0);
         end else begin
            in_valid   = 1'b0;
            sym_ready  = 1'b1;
            force_full = 1'b0;
         end
         #1;
         exp_push = in_valid && !dec_full;
         checks++;
         if (dec_push !== exp_push || in_ready !== !dec_full)
            $display("[TB] FAIL rnd_push: got push=%0b ready=%0b, expected push=%0b ready=%0b",
                     dec_push, in_ready, exp_push, !dec_full);
         else passes++;
         if (sym_valid !== 1'b1) begin
            checks++;
            if (dec_pop !== '0) $display("[TB] FAIL rnd_pop_idle: got %0d, expected 0", dec_pop);
            else passes++;
         end
         if (prev_hold) begin
            checks++;
            if (sym_valid !== 1'b1 || sym !== prev_sym || sym_len !== prev_len || dec_pop !== '0)
               $display("[TB] FAIL rnd_hold: got valid=%0b sym=%0h len=%0d pop=%0d, expected valid=1 sym=%0h len=%0d pop=0",
                        sym_valid, sym, sym_len, dec_pop, prev_sym, prev_len);
            else passes++;
         end else if (sym_valid === 1'b1) begin
            checks++;
            if (dec_pop !== sym_len)
               $display("[TB] FAIL rnd_pop_emit: got %0d, expected %0d", dec_pop, sym_len);
            else passes++;
         end
         if (sym_valid === 1'b1 && sym_ready) begin
            handshakes++;
            checks++;
            if (ref_bits.size() < 2) begin
               $display("[TB] FAIL rnd_symbol: got sym=%0h len=%0d, expected no symbol (%0d bits)",
                        sym, sym_len, ref_bits.size());
            end else begin
               exp_len = 2 * (2 * int'(ref_bits[0]) + int'(ref_bits[1]) + 1);
               if (ref_bits.size() < exp_len) begin
                  $display("[TB] FAIL rnd_symbol: got sym=%0h len=%0d, expected none (need %0d bits, have %0d)",
                           sym, sym_len, exp_len, ref_bits.size());
               end else begin
                  exp_sym = 0;
                  for (int i = 0; i < exp_len; i++) exp_sym = (exp_sym << 1) | int'(ref_bits[i]);
                  if (int'(sym) !== exp_sym || int'(sym_len) !== exp_len)
                     $display("[TB] FAIL rnd_symbol: got sym=%0h len=%0d, expected sym=%0h len=%0d",
                              sym, sym_len, exp_sym, exp_len);
                  else passes++;
                  for (int i = 0; i < exp_len; i++) void'(ref_bits.pop_front());
               end
            end
         end
         if (exp_push) begin
            for (int i = WIDTH_IN - 1; i >= 0; i--) ref_bits.push_back(in_data[i]);
         end
         prev_hold = (sym_valid === 1'b1) && !sym_ready;
         prev_sym  = sym;
         prev_len  = sym_len;
      end
      // After draining, whatever is left must be too short to form a code.
      checks++;
      if (ref_bits.size() >= 2 &&
          ref_bits.size() >= 2 * (2 * int'(ref_bits[0]) + int'(ref_bits[1]) + 1))
         $display("[TB] FAIL rnd_drain: got %0d bits left undecoded, expected an incomplete code", ref_bits.size());
      else passes++;
      checks++;
      if (handshakes < 100)
         $display("[TB] FAIL rnd_activity: got %0d symbols, expected at least 100", handshakes);
      else passes++;
`ifdef VLD_CTRL_STATS_EN
      checks++;
      if (sym_count !== 16'(handshakes))
         $display("[TB] FAIL rnd_sym_count: got %0d, expected %0d", sym_count, 16'(handshakes));
      else passes++;
`endif
   endtask

`ifdef VLD_CTRL_STATS_EN
   // Three accepted symbols from 0x00 (four 2-bit codes, three taken).
   task automatic test_stats();
      do_reset();
      sym_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 20 && sym_valid !== 1'b1; t++) @(negedge clk);
         sym_ready = 1'b1;
         @(negedge clk);
         sym_ready = 1'b0;
      end
      #1;
      checks++;
      if (sym_count !== 16'd3) $display("[TB] FAIL stats_three: got %0d, expected 3", sym_count);
      else passes++;
   endtask
`endif

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_reset_mid_hold();
      test_backpressure();
`ifdef VLD_CTRL_STATS_EN
      test_stats();
`endif
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vld_controller.md
VLD_CONTROLLER -- requirements
Module: vld_controller

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 8, input word width fed to the decoder.
REQ-002 SHALL have parameter WIDTH_OUT, default 8, decoder window width (q) and maximum code length.
REQ-003 SHALL have parameter BUFFER_WIDTH, default 16, decoder buffer depth in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream word available.
REQ-007 SHALL have port in_ready  output  1  word accepted this cycle when in_valid is also high.
REQ-008 SHALL have port in_data  input  WIDTH_IN  upstream word.
REQ-009 SHALL have port dec_push  output  1  push strobe to decoder.
REQ-010 SHALL have port dec_d  output  WIDTH_IN  data to decoder (in_data passthrough).
REQ-011 SHALL have port dec_full  input  1  decoder buffer full.
REQ-012 SHALL have port dec_size  input  log2(BUFFER_WIDTH-1)+1  valid bits held by decoder.
REQ-013 SHALL have port dec_pop  output  log2(WIDTH_OUT-1)+1  bits to consume.
REQ-014 SHALL have port dec_q  input  WIDTH_OUT  next stream bits, MSB first.
REQ-015 SHALL have port sym_valid  output  1  decoded symbol available.
REQ-016 SHALL have port sym_ready  input  1  downstream accepts symbol.
REQ-017 SHALL have port sym  output  WIDTH_OUT  decoded code bits, right-justified, zero-extended.
REQ-018 SHALL have port sym_len  output  log2(WIDTH_OUT-1)+1  length of sym in bits.

Function
REQ-019 in_ready SHALL equal !dec_full; dec_push SHALL equal in_valid && !dec_full; dec_d SHALL equal in_data (push allowed in every state, concurrent with pop).
REQ-020 Code length SHALL be decoded from dec_q[WIDTH_OUT-1:WIDTH_OUT-2]: 00->2, 01->4, 10->6, 11->8 bits (WIDTH_OUT=8).
REQ-021 FSM states SHALL be FILL, EMIT, HOLD, SETTLE.
REQ-022 FILL: if dec_size>=2 and dec_size>=len, register sym=dec_q>>(WIDTH_OUT-len), sym_len=len, go EMIT; else stay FILL.
REQ-023 EMIT: dec_pop SHALL equal registered sym_len for exactly this one cycle; sym_valid=1; sym_ready high -> SETTLE, else -> HOLD.
REQ-024 HOLD: dec_pop=0, sym_valid=1, sym/sym_len stable; sym_ready high -> FILL.
REQ-025 SETTLE: dec_pop=0, sym_valid=0, one cycle for decoder to update q/size, then -> FILL.
REQ-026 dec_pop SHALL be 0 in all states other than EMIT; sym_valid SHALL be 0 in FILL and SETTLE.
REQ-027 Latency: symbol ready in FILL at edge N -> sym_valid and dec_pop high in cycle N+1.
REQ-028 dec_size<2 or dec_size<len SHALL stall in FILL with no pop, no sym_valid.
REQ-029 sym/sym_len SHALL NOT change while sym_valid is high and sym_ready is low.

Reset
REQ-030 rst low SHALL immediately force state FILL, sym_valid=0, sym=0, sym_len=0, dec_pop=0, regardless of clock.
REQ-031 Reset mid-symbol (EMIT/HOLD) SHALL discard the pending symbol; the decoder is reset by the same rst.

Configuration
REQ-032 With VLD_CTRL_STATS_EN defined, SHALL add output sym_count (16 bits), reset 0, incrementing on each sym_valid&&sym_ready, wrapping 0xFFFF->0.
REQ-033 Without VLD_CTRL_STATS_EN, sym_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset asserted mid-HOLD -> sym_valid, dec_pop, sym, sym_len 0 asynchronously; state FILL after release.
REQ-035 Push 0xAB with sym_ready=1 -> one EMIT cycle with dec_pop=6, sym=0x2A, sym_len=6; then stall with dec_size=2 (prefix 11, len 8).
REQ-036 Then push 0x00 -> EMIT with dec_pop=8, sym=0xC0, sym_len=8.
REQ-037 sym_ready=0 for 5 cycles after EMIT -> sym_valid held, sym stable, dec_pop high only in EMIT cycle; release -> FILL next cycle.
REQ-038 dec_full=1 with in_valid=1 -> in_ready=0, dec_push=0; dec_full drops -> dec_push=1 same cycle.
REQ-039 With VLD_CTRL_STATS_EN, 3 accepted symbols -> sym_count=3; preset count at 0xFFFF plus one accept -> 0.
